// File: rtl/br_demux_pkg.sv
// Shared definitions for the four-lane buffered demultiplexer.
package br_demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 8;

    typedef logic [1:0] lane_sel_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Increment a delivery counter, holding at the top value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/br_lane_fifo.sv
// Per-lane FIFO: registered storage, combinational head, no pass-through when full.
module br_lane_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);
    assign head  = mem[rd_ptr];

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Storage write; data bits carry no reset, stale entries are masked by occupancy.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/br_4_demux_14.sv
// Four-lane buffered demultiplexer with per-lane FIFOs and saturating delivery counters.
module br_4_demux_14
    import br_demux_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [1:0]   in_sel,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [W-1:0] out_data0,
    output logic [W-1:0] out_data1,
    output logic [W-1:0] out_data2,
    output logic [W-1:0] out_data3,
    output logic [7:0]   lane_count0,
    output logic [7:0]   lane_count1,
    output logic [7:0]   lane_count2,
    output logic [7:0]   lane_count3
);

    lane_sel_t              sel;
    logic [NUM_LANES-1:0]   full;
    logic [NUM_LANES-1:0]   empty;
    logic [NUM_LANES-1:0]   push;
    logic [NUM_LANES-1:0]   pop;
    logic [W-1:0]           head [NUM_LANES];
    logic [CNT_W-1:0]       cnt  [NUM_LANES];

    assign sel       = in_sel;
    // Ready reflects only the selected lane's occupancy, independent of in_valid.
    assign in_ready  = ~full[sel];
    assign out_valid = ~empty;
    assign pop       = ~empty & out_ready;

    // Route an accepted word to exactly one lane.
    always_comb begin
        push = '0;
        if (in_valid && in_ready) push[sel] = 1'b1;
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        br_lane_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .din   (in_data),
            .full  (full[k]),
            .pop   (pop[k]),
            .empty (empty[k]),
            .head  (head[k])
        );

        // Delivery counter for lane k, saturating at its maximum.
        always_ff @(posedge clk) begin
            if (rst)         cnt[k] <= '0;
            else if (pop[k]) cnt[k] <= sat_inc(cnt[k]);
        end
    end

    assign out_data0   = head[0];
    assign out_data1   = head[1];
    assign out_data2   = head[2];
    assign out_data3   = head[3];
    assign lane_count0 = cnt[0];
    assign lane_count1 = cnt[1];
    assign lane_count2 = cnt[2];
    assign lane_count3 = cnt[3];

endmodule

// File: tb/tb_br_4_demux_14.sv
// Bench for br_4_demux_14: directed vector table, counter saturation, reset flush, random traffic.
module tb_br_4_demux_14;

    localparam int W     = 4;
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0]   lane_count0, lane_count1, lane_count2, lane_count3;

    br_4_demux_14 #(.W(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_sel      (in_sel),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data0   (out_data0),
        .out_data1   (out_data1),
        .out_data2   (out_data2),
        .out_data3   (out_data3),
        .lane_count0 (lane_count0),
        .lane_count1 (lane_count1),
        .lane_count2 (lane_count2),
        .lane_count3 (lane_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] od  [4];
    logic [7:0]   lc  [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;
    assign lc[0] = lane_count0;
    assign lc[1] = lane_count1;
    assign lc[2] = lane_count2;
    assign lc[3] = lane_count3;

    // Scoreboard: one expected-word queue and one expected count per lane.
    logic [W-1:0] sb [4][$];
    int           mcnt [4];

    int nvec;
    int nerr;

    typedef struct {
        logic         iv;
        logic [1:0]   sel;
        logic [W-1:0] d;
        logic [3:0]   ordy;
        logic         exp_ir;
        logic [3:0]   exp_ov;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_ov();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (sb[k].size() != 0);
        return v;
    endfunction

    // Drive one cycle, check against the scoreboard, then advance the model and clock.
    task automatic step(input logic iv, input logic [1:0] sel, input logic [W-1:0] d,
                        input logic [3:0] ordy, input logic has_exp,
                        input logic exp_ir, input logic [3:0] exp_ov);
        logic acc;
        in_valid  = iv;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        #3;
        chk("in_ready", {31'b0, in_ready}, {31'b0, (sb[sel].size() < DEPTH)});
        chk("out_valid", {28'b0, out_valid}, {28'b0, model_ov()});
        if (has_exp) begin
            chk("tbl_in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
            chk("tbl_out_valid", {28'b0, out_valid}, {28'b0, exp_ov});
        end
        for (int k = 0; k < 4; k++)
            chk($sformatf("lane_count%0d", k), {24'b0, lc[k]}, mcnt[k]);
        acc = iv && (sb[sel].size() < DEPTH);
        for (int k = 0; k < 4; k++) begin
            if (sb[k].size() != 0 && ordy[k]) begin
                chk($sformatf("out_data%0d", k), {28'b0, od[k]}, {28'b0, sb[k][0]});
                void'(sb[k].pop_front());
                if (mcnt[k] < 255) mcnt[k]++;
            end
        end
        if (acc) sb[sel].push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_sel    = 2'd0;
        in_data   = 4'hF;
        out_ready = 4'b1111;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb[k].delete();
            mcnt[k] = 0;
        end
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #2;
        chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("rst_lane_count%0d", k), {24'b0, lc[k]}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        for (int k = 0; k < 4; k++) mcnt[k] = 0;

        //            iv    sel   d      ordy     ir    ov
        tbl[0]  = '{1'b1, 2'd2, 4'hA, 4'b0100, 1'b1, 4'b0000};
        tbl[1]  = '{1'b0, 2'd0, 4'h0, 4'b0100, 1'b1, 4'b0100};
        tbl[2]  = '{1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0000};
        tbl[3]  = '{1'b1, 2'd1, 4'h1, 4'b0000, 1'b1, 4'b0000};
        tbl[4]  = '{1'b1, 2'd1, 4'h2, 4'b0000, 1'b1, 4'b0010};
        tbl[5]  = '{1'b1, 2'd1, 4'h3, 4'b0000, 1'b0, 4'b0010};
        tbl[6]  = '{1'b1, 2'd3, 4'h7, 4'b0000, 1'b1, 4'b0010};
        tbl[7]  = '{1'b0, 2'd1, 4'h0, 4'b0010, 1'b0, 4'b1010};
        tbl[8]  = '{1'b0, 2'd1, 4'h0, 4'b0010, 1'b1, 4'b1010};
        tbl[9]  = '{1'b0, 2'd0, 4'h0, 4'b1000, 1'b1, 4'b1000};
        tbl[10] = '{1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0000};
        tbl[11] = '{1'b1, 2'd0, 4'h8, 4'b0000, 1'b1, 4'b0000};
        tbl[12] = '{1'b1, 2'd0, 4'h9, 4'b0000, 1'b1, 4'b0001};
        tbl[13] = '{1'b1, 2'd0, 4'hB, 4'b0001, 1'b0, 4'b0001};
        tbl[14] = '{1'b1, 2'd0, 4'hC, 4'b0000, 1'b1, 4'b0001};
        tbl[15] = '{1'b0, 2'd0, 4'h0, 4'b0001, 1'b0, 4'b0001};
        tbl[16] = '{1'b0, 2'd0, 4'h0, 4'b0001, 1'b1, 4'b0001};
        tbl[17] = '{1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0000};
        tbl[18] = '{1'b1, 2'd2, 4'h3, 4'b0000, 1'b1, 4'b0000};
        tbl[19] = '{1'b1, 2'd2, 4'h4, 4'b0100, 1'b1, 4'b0100};
        tbl[20] = '{1'b1, 2'd2, 4'h5, 4'b0100, 1'b1, 4'b0100};
        tbl[21] = '{1'b1, 2'd2, 4'h6, 4'b0100, 1'b1, 4'b0100};
        tbl[22] = '{1'b0, 2'd2, 4'h0, 4'b0100, 1'b1, 4'b0100};
        tbl[23] = '{1'b0, 2'd2, 4'h0, 4'b0000, 1'b1, 4'b0000};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 24; i++)
            step(tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].ordy, 1'b1, tbl[i].exp_ir, tbl[i].exp_ov);
        chk("lane_count2_after_table", {24'b0, lane_count2}, 32'd5);
        chk("lane_count1_after_table", {24'b0, lane_count1}, 32'd2);

        // Counter saturation on lane 3: stream with one push and one deliver per cycle.
        for (int i = 0; i < 302; i++)
            step(1'b1, 2'd3, W'(i), 4'b1000, 1'b0, 1'b0, 4'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 2'd3, 4'h0, 4'b1000, 1'b0, 1'b0, 4'b0);
        chk("lane_count3_saturated", {24'b0, lane_count3}, 32'd255);
        step(1'b0, 2'd3, 4'h0, 4'b0000, 1'b0, 1'b0, 4'b0);
        chk("lane_count3_held", {24'b0, lane_count3}, 32'd255);

        // Reset flush: lane 0 holds two words, lane 1 one word.
        step(1'b1, 2'd0, 4'h1, 4'b0000, 1'b0, 1'b0, 4'b0);
        step(1'b1, 2'd0, 4'h2, 4'b0000, 1'b0, 1'b0, 4'b0);
        step(1'b1, 2'd1, 4'h3, 4'b0000, 1'b1, 1'b1, 4'b0001);
        chk("pre_rst_out_valid", {28'b0, out_valid}, 32'h3);
        do_reset();
        for (int i = 0; i < 3; i++)
            step(1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 1'b1, 4'b0000);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom),
                 4'($urandom), 1'b0, 1'b0, 4'b0);
        for (int i = 0; i < 4; i++)
            step(1'b0, 2'd0, 4'h0, 4'b1111, 1'b0, 1'b0, 4'b0);
        chk("drained_out_valid", {28'b0, out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
